serial_frame_sequencer: RTL and testbench
=========================================

// Module: serial_frame_sequencer
// PURPOSE
//  Upstream controller for the serial pattern transmitter. Drives its Start/Polarity/State
//  inputs to issue a programmed run of frames and waits for eoc between frames.
//  Enforces an inter-frame idle gap and flags a transmitter that never completes a frame.
//  Sits between the test-control logic (go/stop) and the transmitter in the MIPI DAC test path.
// PARAMETERS
//  NUM_FRAMES      4    frames per run; 0 = continuous until stop
//  GAP_CYCLES      8    idle cycles with Start=0 between frames (min 1)
//  TIMEOUT_CYCLES  120  max cycles in RUN without eoc before error (frame is ~101 cycles)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-low
//  go           in   1   start a run; sampled in IDLE/ERR only
//  stop         in   1   end run after the current frame completes
//  fixed_en     in   1   1 = every frame uses fixed_sel; 0 = pattern rotation
//  fixed_sel    in   2   {Polarity,State} used when fixed_en=1
//  eoc          in   1   end-of-frame flag from transmitter
//  Start        out  1   transmit enable to transmitter
//  Polarity     out  1   pattern select bit 1
//  State        out  1   pattern select bit 0
//  busy         out  1   1 in SETUP/RUN/GAP
//  done         out  1   one-cycle pulse when a run ends normally
//  timeout_err  out  1   sticky; set on timeout, cleared by go or reset
//  frame_cnt    out  16  frames completed in current run; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; Start=0, Polarity=1, State=1, busy=0, done=0,
//    timeout_err=0, frame_cnt=0, rotation index=0. All outputs registered.
//  - IDLE: go=1 -> SETUP, frame_cnt<=0, timeout_err<=0, rotation index<=0.
//  - SETUP (1 cycle): Start=0; Polarity/State <= fixed_sel if fixed_en else rotation entry;
//    -> RUN. Selection is stable >=1 cycle before Start rises and is held through RUN.
//  - Rotation order {Polarity,State}: 11,10,01,00, wrap to 11; index advances per completed frame.
//  - RUN: Start=1; timeout counter increments each cycle from 0.
//    eoc=1 sampled -> Start<=0, frame_cnt+1, -> GAP (if stop seen or count reached: DONE).
//    counter==TIMEOUT_CYCLES with eoc=0 -> Start<=0, timeout_err<=1, -> ERR.
//  - GAP: Start=0; count GAP_CYCLES; exit only when count elapsed AND eoc=0 (transmitter cleared).
//    -> SETUP for next frame.
//  - Run end: frame_cnt==NUM_FRAMES (NUM_FRAMES!=0) or stop latched -> DONE.
//  - DONE (1 cycle): done=1, Start=0 -> IDLE. frame_cnt holds until next go.
//  - ERR: Start=0, busy=0; go=1 -> SETUP (clears error, restarts run).
//  - stop: latched in any busy state; never truncates a frame in RUN; in SETUP/GAP ends run
//    at next state boundary -> DONE without a further frame. stop in IDLE ignored.
//  - go while busy ignored. go and stop same cycle in IDLE: run starts, stop latched, run
//    ends after first frame.
//  - eoc=1 outside RUN ignored (only gates GAP exit).
//  - Reset mid-frame: Start drops immediately (async), no done pulse.
//  - Counters: timeout counter width ceil(log2(TIMEOUT_CYCLES+1)); gap counter
//    ceil(log2(GAP_CYCLES+1)); no overflow within limits.
// CONFIGURATION
//  SEQ_LFSR_EN defined: rotation replaced by 4-bit LFSR (x^4+x^3+1, seed 4'b1001 on reset/go),
//    {Polarity,State} = LFSR[1:0]; LFSR steps once per completed frame. fixed_en still overrides.
//  SEQ_LFSR_EN undefined: deterministic rotation 11,10,01,00 as above; no LFSR logic.
// TESTING
//  1. Reset, go pulse, NUM_FRAMES=4, eoc model after 101 RUN cycles -> selects 11,10,01,00,
//     frame_cnt=4, one done pulse, busy low after.
//  2. fixed_en=1, fixed_sel=2'b01, 2 frames -> Polarity=0, State=1 every frame; Start low
//     >= GAP_CYCLES=8 cycles between frames.
//  3. eoc held 0 -> Start drops after 120 RUN cycles, timeout_err=1 sticky, go clears it and
//     restarts with frame_cnt=0.
//  4. NUM_FRAMES=0, stop pulsed mid-frame 3 -> frame 3 completes, frame_cnt=3, done pulse,
//     no 4th Start.
//  5. rst low at RUN cycle 50 -> Start=0 same cycle, all outputs at reset values, no done.
//  6. eoc kept high 5 cycles after Start falls -> GAP exit delayed until eoc=0, then SETUP.

Source files
------------

// File: rtl/serial_frame_sequencer.sv
// Frame sequencer for the serial pattern transmitter: issues a run of frames, enforces idle gaps, flags timeouts.
// Optional SEQ_LFSR_EN: pattern selection from a 4-bit LFSR instead of the fixed 11,10,01,00 rotation.
module serial_frame_sequencer #(
  parameter int NUM_FRAMES     = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        stop,
  input  logic        fixed_en,
  input  logic [1:0]  fixed_sel,
  input  logic        eoc,
  output logic        Start,
  output logic        Polarity,
  output logic        State,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] frame_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

`ifdef SEQ_LFSR_EN
  localparam int SEQ_W = 4;
  localparam logic [SEQ_W-1:0] SEQ_SEED = 4'b1001;
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction
  function automatic logic [1:0] seq_sel(input logic [SEQ_W-1:0] v);
    return v[1:0];
  endfunction
`else
  localparam int SEQ_W = 2;
  localparam logic [SEQ_W-1:0] SEQ_SEED = 2'd0;
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] v);
    return v + 2'd1;
  endfunction
  // Index 0..3 maps to 11,10,01,00.
  function automatic logic [1:0] seq_sel(input logic [SEQ_W-1:0] v);
    return ~v;
  endfunction
`endif

  typedef enum logic [2:0] {IDLE, SETUP, RUN, GAP, DONE, ERR} state_t;

  state_t            st, st_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_nx;
  logic [SEQ_W-1:0]  seq, seq_nx;
  logic              stop_lat, stop_nx;
  logic              err_nx;
  logic [15:0]       frame_nx;
  logic              last_frame;

  assign last_frame = (NUM_FRAMES != 0) && ((frame_cnt + 16'd1) == 16'(NUM_FRAMES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      seq         <= SEQ_SEED;
      stop_lat    <= 1'b0;
      Start       <= 1'b0;
      Polarity    <= 1'b1;
      State       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      st          <= st_nx;
      tmo_cnt     <= tmo_nx;
      gap_cnt     <= gap_nx;
      seq         <= seq_nx;
      stop_lat    <= stop_nx;
      timeout_err <= err_nx;
      frame_cnt   <= frame_nx;
      // Outputs decoded from the next state so they line up with the state register.
      Start       <= (st_nx == RUN);
      busy        <= (st_nx == SETUP) || (st_nx == RUN) || (st_nx == GAP);
      done        <= (st_nx == DONE);
      if (st_nx == SETUP)
        {Polarity, State} <= fixed_en ? fixed_sel : seq_sel(seq_nx);
    end
  end

  always_comb begin
    st_nx    = st;
    tmo_nx   = tmo_cnt;
    gap_nx   = gap_cnt;
    seq_nx   = seq;
    stop_nx  = stop_lat;
    err_nx   = timeout_err;
    frame_nx = frame_cnt;
    case (st)
      IDLE, ERR: begin
        if (go) begin
          st_nx    = SETUP;
          frame_nx = '0;
          err_nx   = 1'b0;
          seq_nx   = SEQ_SEED;
          stop_nx  = stop;
        end
      end
      SETUP: begin
        tmo_nx  = '0;
        stop_nx = stop_lat | stop;
        // A stop latched together with go still lets the first frame run.
        st_nx   = stop ? DONE : RUN;
      end
      RUN: begin
        stop_nx = stop_lat | stop;
        if (eoc) begin
          frame_nx = frame_cnt + 16'd1;
          seq_nx   = seq_next(seq);
          gap_nx   = '0;
          st_nx    = (stop_lat || stop || last_frame) ? DONE : GAP;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_nx = 1'b1;
          st_nx  = ERR;
        end else begin
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      GAP: begin
        stop_nx = stop_lat | stop;
        if (gap_cnt != GAP_W'(GAP_CYCLES - 1))
          gap_nx = gap_cnt + GAP_W'(1);
        else if (!eoc)
          st_nx = (stop_lat || stop) ? DONE : SETUP;
      end
      DONE: begin
        st_nx   = IDLE;
        stop_nx = 1'b0;
      end
      default: st_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Bench for serial_frame_sequencer: table-driven runs plus timeout, stop, go+stop and reset sequences.
module tb_serial_frame_sequencer;

  logic        clk, rst;
  logic        go, go_c, stop, fixed_en;
  logic [1:0]  fixed_sel;
  logic [1:0]  eoc_v;
  logic        Start, Polarity, State, busy, done, timeout_err;
  logic [15:0] frame_cnt;
  logic        Start_c, Polarity_c, State_c, busy_c, done_c, timeout_err_c;
  logic [15:0] frame_cnt_c;
  logic [1:0]  st_v;

  serial_frame_sequencer #(.NUM_FRAMES(4), .GAP_CYCLES(8), .TIMEOUT_CYCLES(120)) u_dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .fixed_en(fixed_en), .fixed_sel(fixed_sel),
    .eoc(eoc_v[0]), .Start(Start), .Polarity(Polarity), .State(State), .busy(busy),
    .done(done), .timeout_err(timeout_err), .frame_cnt(frame_cnt));

  serial_frame_sequencer #(.NUM_FRAMES(0), .GAP_CYCLES(8), .TIMEOUT_CYCLES(120)) u_cont (
    .clk(clk), .rst(rst), .go(go_c), .stop(stop), .fixed_en(fixed_en), .fixed_sel(fixed_sel),
    .eoc(eoc_v[1]), .Start(Start_c), .Polarity(Polarity_c), .State(State_c), .busy(busy_c),
    .done(done_c), .timeout_err(timeout_err_c), .frame_cnt(frame_cnt_c));

  assign st_v = {Start_c, Start};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: eoc after 101 Start-high cycles, optionally held high afterwards.
  bit eoc_en = 1'b1;
  int eoc_hold = 0;
  int run_n [2] = '{0, 0};
  int hold_n [2] = '{0, 0};
  initial eoc_v = 2'b00;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (st_v[i]) begin
        run_n[i]++;
        eoc_v[i] = eoc_en && (run_n[i] == 101);
        if (eoc_v[i]) hold_n[i] = eoc_hold;
      end else begin
        run_n[i] = 0;
        if (hold_n[i] > 0) begin
          eoc_v[i] = 1'b1;
          hold_n[i]--;
        end else begin
          eoc_v[i] = 1'b0;
        end
      end
    end
  end

  // Monitor of the main instance: frame selections, Start-low gaps, done pulses.
  logic       prev_st = 1'b0, prev_st_c = 1'b0;
  logic [1:0] prev_sel = 2'b11;
  int         low_n = 0, done_n = 0, rise_c = 0;
  bit         seen_fall = 1'b0;
  logic [1:0] sels [$];
  int         gaps [$];
  always @(negedge clk) begin
    if (done) done_n++;
    if (Start && !prev_st) begin
      sels.push_back({Polarity, State});
      chk("sel_stable_before_start", {30'd0, Polarity, State}, {30'd0, prev_sel});
      if (seen_fall) gaps.push_back(low_n);
    end
    if (!Start && prev_st) seen_fall = 1'b1;
    if (!Start) low_n++; else low_n = 0;
    if (Start_c && !prev_st_c) rise_c++;
    prev_st   = Start;
    prev_st_c = Start_c;
    prev_sel  = {Polarity, State};
  end

  task automatic clear_mon();
    sels.delete();
    gaps.delete();
    seen_fall = 1'b0;
    done_n    = 0;
  endtask

  task automatic pulse_go(input bit cont, input bit with_stop);
    @(negedge clk);
    if (cont) go_c = 1'b1; else go = 1'b1;
    stop = with_stop;
    @(negedge clk);
    go = 1'b0; go_c = 1'b0; stop = 1'b0;
  endtask

  // which: 0 done, 1 done_c, 2 Start high, 3 rise_c reaches 3
  task automatic wait_for(input int which, input int bud, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bud && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = done;
        1: hit = done_c;
        2: hit = Start;
        default: hit = (rise_c >= 3);
      endcase
    end
    if (!hit) begin
      nvec++;
      nbad++;
      $display("FAIL %s: wait expired after %0d cycles", name, bud);
    end
  endtask

  typedef struct {
    bit         fen;
    logic [1:0] fsel;
    int         hold;
    logic [7:0] sels;
    int         gap;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic [7:0] s;
    int hi;
    tbl[0] = '{1'b0, 2'b00, 0,  8'b11_10_01_00, 9};
    tbl[1] = '{1'b1, 2'b01, 0,  8'b01_01_01_01, 9};
    tbl[2] = '{1'b0, 2'b00, 12, 8'b11_10_01_00, 14};
    tbl[3] = '{1'b1, 2'b10, 5,  8'b10_10_10_10, 9};

    rst = 1'b0; go = 1'b0; go_c = 1'b0; stop = 1'b0; fixed_en = 1'b0; fixed_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {10'd0, Start, Polarity, State, busy, done, timeout_err, frame_cnt},
        {10'd0, 6'b011000, 16'h0000});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      fixed_en  = tbl[v].fen;
      fixed_sel = tbl[v].fsel;
      eoc_hold  = tbl[v].hold;
      eoc_en    = 1'b1;
      clear_mon();
      pulse_go(1'b0, 1'b0);
      wait_for(0, 2000, "run_done");
      chk("run_frame_cnt", {16'd0, frame_cnt}, 32'd4);
      @(negedge clk);
      chk("run_idle_after", {30'd0, busy, done}, 32'd0);
      chk("run_done_pulses", done_n, 32'd1);
      chk("run_num_frames", sels.size(), 32'd4);
      s = tbl[v].sels;
      for (int i = 0; i < 4 && i < sels.size(); i++)
        chk("run_sel", {30'd0, sels[i]}, {30'd0, s[7-2*i -: 2]});
      chk("run_num_gaps", gaps.size(), 32'd3);
      foreach (gaps[i]) chk("run_gap_len", gaps[i], tbl[v].gap);
    end

    // Timeout: transmitter never completes.
    fixed_en = 1'b0; eoc_hold = 0; eoc_en = 1'b0;
    clear_mon();
    pulse_go(1'b0, 1'b0);
    wait_for(2, 20, "tmo_start");
    hi = 1;
    for (int i = 0; i < 200 && Start; i++) begin
      @(negedge clk);
      if (Start) hi++;
    end
    chk("tmo_start_high_cycles", hi, 32'd120);
    chk("tmo_err_set", {30'd0, timeout_err, busy}, 32'd2);
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
    chk("tmo_no_done", done_n, 32'd0);
    eoc_en = 1'b1;
    pulse_go(1'b0, 1'b0);
    chk("tmo_restart", {14'd0, timeout_err, busy, frame_cnt}, {14'd0, 2'b01, 16'd0});
    wait_for(0, 2000, "tmo_restart_done");
    chk("tmo_restart_frames", {16'd0, frame_cnt}, 32'd4);

    // Continuous run ended by stop in the middle of frame 3.
    rise_c = 0;
    pulse_go(1'b1, 1'b0);
    wait_for(3, 1000, "cont_frame3");
    repeat (50) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_for(1, 300, "cont_done");
    chk("cont_frame_cnt", {16'd0, frame_cnt_c}, 32'd3);
    repeat (300) @(negedge clk);
    chk("cont_no_4th_start", rise_c, 32'd3);
    chk("cont_idle", {31'd0, busy_c}, 32'd0);

    // go and stop together: exactly one frame.
    rise_c = 0;
    pulse_go(1'b1, 1'b1);
    wait_for(1, 400, "gostop_done");
    chk("gostop_frame_cnt", {16'd0, frame_cnt_c}, 32'd1);
    chk("gostop_starts", rise_c, 32'd1);

    // Asynchronous reset during RUN cycle 50.
    clear_mon();
    pulse_go(1'b0, 1'b0);
    wait_for(2, 20, "rst_start");
    repeat (49) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_midframe_outputs", {10'd0, Start, Polarity, State, busy, done, timeout_err, frame_cnt},
        {10'd0, 6'b011000, 16'h0000});
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_n, 32'd0);
    chk("rst_idle", {30'd0, busy, Start}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
